// File: rtl/window_assembler_if.sv
// Pixel-in / window-out bundle between the image-memory return path and the median core.
// Handshake rule (both streams): a beat transfers on a rising edge where valid and ready are both 1;
// ready never depends combinationally on valid, and a held window stays stable until it transfers.
interface window_assembler_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                     start;
  logic [PIXEL_WIDTH-1:0]   pixelIn;
  logic                     pixelValid;
  logic                     pixelReady;
  logic [9*PIXEL_WIDTH-1:0] windowOut;
  logic                     windowValid;
  logic                     windowReady;
  logic [7:0]               xOut;
  logic [7:0]               yOut;
  logic                     busy;
  logic                     frameDone;
  // FSM debug view: 0 = IDLE, 1 = COLLECT, 2 = HOLD
  logic [1:0]               stateDbg;

  modport master (
    output start, pixelIn, pixelValid, windowReady,
    input  pixelReady, windowOut, windowValid, xOut, yOut, busy, frameDone, stateDbg
  );

  modport slave (
    input  start, pixelIn, pixelValid, windowReady,
    output pixelReady, windowOut, windowValid, xOut, yOut, busy, frameDone, stateDbg
  );
endinterface

// File: rtl/window_assembler.sv
// Packs 3x3 pixel returns (column offset fastest) into one window word, tags it with its
// top-left (x, y) and signals end of frame after the last window is taken by the median core.
module window_assembler #(
  parameter int PIXEL_WIDTH = 8,
  parameter int X_LAST      = 237,
  parameter int Y_LAST      = 177
) (
  input logic              clk,
  input logic              reset,
  window_assembler_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [7:0] X_MAX = 8'(X_LAST);
  localparam logic [7:0] Y_MAX = 8'(Y_LAST);

  state_t                   state;
  logic [3:0]               k;
  logic [PIXEL_WIDTH-1:0]   slots [0:7];
  logic [7:0]               x;
  logic [7:0]               y;
  logic [9*PIXEL_WIDTH-1:0] windowOut;
  logic                     windowValid;
  logic [7:0]               xOut;
  logic [7:0]               yOut;
  logic                     frameDone;
  logic [9*PIXEL_WIDTH-1:0] windowNext;

  assign bus.pixelReady  = (state == COLLECT);
  assign bus.busy        = (state != IDLE);
  assign bus.stateDbg    = state;
  assign bus.windowOut   = windowOut;
  assign bus.windowValid = windowValid;
  assign bus.xOut        = xOut;
  assign bus.yOut        = yOut;
  assign bus.frameDone   = frameDone;

  // The ninth byte bypasses the slot store so the window loads on the same edge it arrives.
  always_comb begin
    windowNext = '0;
    for (int s = 0; s < 8; s++) begin
      windowNext[s*PIXEL_WIDTH +: PIXEL_WIDTH] = slots[s];
    end
    windowNext[8*PIXEL_WIDTH +: PIXEL_WIDTH] = bus.pixelIn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= 4'd0;
      x           <= 8'd0;
      y           <= 8'd0;
      windowOut   <= '0;
      windowValid <= 1'b0;
      xOut        <= 8'd0;
      yOut        <= 8'd0;
      frameDone   <= 1'b0;
      for (int s = 0; s < 8; s++) begin
        slots[s] <= '0;
      end
    end else begin
      frameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= COLLECT;
            k     <= 4'd0;
            x     <= 8'd0;
            y     <= 8'd0;
          end
        end
        COLLECT: begin
          if (bus.pixelValid) begin
            if (k == 4'd8) begin
              windowOut   <= windowNext;
              windowValid <= 1'b1;
              xOut        <= x;
              yOut        <= y;
              k           <= 4'd0;
              state       <= HOLD;
            end else begin
              slots[k[2:0]] <= bus.pixelIn;
              k             <= k + 4'd1;
            end
          end
        end
        HOLD: begin
          if (windowValid && bus.windowReady) begin
            windowValid <= 1'b0;
            if (x == X_MAX && y == Y_MAX) begin
              x         <= 8'd0;
              y         <= 8'd0;
              frameDone <= 1'b1;
              state     <= IDLE;
            end else begin
              if (x < X_MAX) begin
                x <= x + 8'd1;
              end else begin
                x <= 8'd0;
                y <= y + 8'd1;
              end
              state <= COLLECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_window_assembler.sv
// Bench for window_assembler: a full-size instance for tagging and row wrap, plus a small-frame
// instance so complete frames (frameDone, relaunch, return to idle) fit in a short run.
module tb_window_assembler;
  localparam int PW           = 8;
  localparam int XL_B         = 4;
  localparam int YL_B         = 2;
  localparam int CYCLE_BUDGET = 30000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_assembler_if #(.PIXEL_WIDTH(PW)) busA ();
  window_assembler_if #(.PIXEL_WIDTH(PW)) busB ();

  window_assembler #(.PIXEL_WIDTH(PW)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  window_assembler #(.PIXEL_WIDTH(PW), .X_LAST(XL_B), .Y_LAST(YL_B)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  // Per-instance drive and observe arrays (index 0 = A, 1 = B)
  logic        dStart [2];
  logic        dValid [2];
  logic        dReady [2];
  logic [7:0]  dPix   [2];
  logic        oReady [2];
  logic        oValid [2];
  logic        oBusy  [2];
  logic        oDone  [2];
  logic [71:0] oWin   [2];
  logic [7:0]  oX     [2];
  logic [7:0]  oY     [2];
  logic [1:0]  oState [2];

  assign busA.start = dStart[0];  assign busB.start = dStart[1];
  assign busA.pixelValid = dValid[0];  assign busB.pixelValid = dValid[1];
  assign busA.windowReady = dReady[0];  assign busB.windowReady = dReady[1];
  assign busA.pixelIn = dPix[0];  assign busB.pixelIn = dPix[1];
  assign oReady[0] = busA.pixelReady;  assign oReady[1] = busB.pixelReady;
  assign oValid[0] = busA.windowValid;  assign oValid[1] = busB.windowValid;
  assign oBusy[0] = busA.busy;  assign oBusy[1] = busB.busy;
  assign oDone[0] = busA.frameDone;  assign oDone[1] = busB.frameDone;
  assign oWin[0] = busA.windowOut;  assign oWin[1] = busB.windowOut;
  assign oX[0] = busA.xOut;  assign oX[1] = busB.xOut;
  assign oY[0] = busA.yOut;  assign oY[1] = busB.yOut;
  assign oState[0] = busA.stateDbg;  assign oState[1] = busB.stateDbg;

  // Reference model: windows are counted, coordinates derived from the count by div/mod
  int          xLast [2] = '{237, XL_B};
  int          yLast [2] = '{177, YL_B};
  bit          mIdle [2];
  bit          mHold [2];
  bit          mDone [2];
  int          mCnt  [2];
  int          mN    [2];
  int          mX    [2];
  int          mY    [2];
  logic [71:0] mAcc  [2];
  logic [71:0] mWin  [2];
  int          winAcc [2];
  int          frames [2];

  int nChecks = 0;
  int nPass   = 0;
  int cycles  = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycles);
  endtask

  task automatic modelReset(input int i);
    mIdle[i] = 1; mHold[i] = 0; mDone[i] = 0; mCnt[i] = 0; mN[i] = 0;
    mX[i] = 0; mY[i] = 0; mAcc[i] = '0; mWin[i] = '0;
  endtask

  task automatic modelStep(input int i);
    mDone[i] = 0;
    if (mIdle[i]) begin
      if (dStart[i]) begin
        mIdle[i] = 0; mN[i] = 0; mCnt[i] = 0; mAcc[i] = '0;
      end
    end else if (mHold[i]) begin
      if (dReady[i]) begin
        mHold[i] = 0;
        mN[i]++;
        winAcc[i]++;
        if (mN[i] == (xLast[i] + 1) * (yLast[i] + 1)) begin
          mIdle[i] = 1; mN[i] = 0; mDone[i] = 1; frames[i]++;
        end
      end
    end else if (dValid[i]) begin
      mAcc[i] = mAcc[i] | (72'(dPix[i]) << (8 * mCnt[i]));
      mCnt[i]++;
      if (mCnt[i] == 9) begin
        mWin[i] = mAcc[i];
        mX[i] = mN[i] % (xLast[i] + 1);
        mY[i] = mN[i] / (xLast[i] + 1);
        mHold[i] = 1; mCnt[i] = 0; mAcc[i] = '0;
      end
    end
  endtask

  task automatic checkInst(input int i);
    string p;
    p = (i == 0) ? "A." : "B.";
    check({p, "pixelReady"}, 72'(oReady[i]), 72'(!mIdle[i] && !mHold[i]));
    check({p, "windowValid"}, 72'(oValid[i]), 72'(mHold[i]));
    check({p, "busy"}, 72'(oBusy[i]), 72'(!mIdle[i]));
    check({p, "frameDone"}, 72'(oDone[i]), 72'(mDone[i]));
    if (mHold[i]) begin
      check({p, "windowOut"}, oWin[i], mWin[i]);
      check({p, "xOut"}, 72'(oX[i]), 72'(mX[i]));
      check({p, "yOut"}, 72'(oY[i]), 72'(mY[i]));
    end
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  endtask

  // One clock: compare outputs, advance model with the applied inputs, move to next falling edge
  task automatic cycle();
    for (int i = 0; i < 2; i++) checkInst(i);
    for (int i = 0; i < 2; i++) begin
      if (reset) modelReset(i);
      else modelStep(i);
    end
    @(posedge clk);
    @(negedge clk);
    cycles++;
    if (cycles > CYCLE_BUDGET) begin
      check("cycleBudget", 72'(cycles), 72'(CYCLE_BUDGET));
      summary();
    end
  endtask

  task automatic checkResetState(input int i);
    check("rst.windowOut", oWin[i], 72'd0);
    check("rst.windowValid", 72'(oValid[i]), 72'd0);
    check("rst.pixelReady", 72'(oReady[i]), 72'd0);
    check("rst.xy", 72'({oX[i], oY[i]}), 72'd0);
    check("rst.busyDone", 72'({oBusy[i], oDone[i]}), 72'd0);
  endtask

  task automatic randomBeat(input int i, input int validPct, input int readyPct);
    dValid[i] = ($urandom_range(99, 0) < validPct);
    dPix[i]   = 8'($urandom);
    dReady[i] = ($urandom_range(99, 0) < readyPct);
    cycle();
  endtask

  task automatic collectOnly(input int i);
    dReady[i] = 0;
    while (!mHold[i]) begin
      dValid[i] = ($urandom_range(99, 0) < 70);
      dPix[i]   = 8'($urandom);
      cycle();
    end
    dValid[i] = 0;
  endtask

  task automatic acceptNow(input int i);
    dReady[i] = 1;
    cycle();
    dReady[i] = 0;
  endtask

  initial begin
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      dStart[i] = 0; dValid[i] = 0; dReady[i] = 0; dPix[i] = 8'd0;
      winAcc[i] = 0; frames[i] = 0;
      modelReset(i);
    end
    @(negedge clk);
    @(negedge clk);
    checkResetState(0);
    checkResetState(1);
    reset = 0;

    // First window: bytes 1..9 back to back, then held for 5 cycles
    dStart[0] = 1; cycle(); dStart[0] = 0;
    for (int p = 1; p <= 9; p++) begin
      dValid[0] = 1; dPix[0] = 8'(p); cycle();
    end
    dValid[0] = 0;
    check("t1.windowValid", 72'(oValid[0]), 72'd1);
    check("t1.windowOut", oWin[0], 72'h090807060504030201);
    check("t1.xy", 72'({oX[0], oY[0]}), 72'd0);
    check("t1.pixelReady", 72'(oReady[0]), 72'd0);
    for (int c = 0; c < 5; c++) begin
      dValid[0] = 1; dPix[0] = 8'($urandom); cycle();
    end
    dValid[0] = 0;
    check("t2.heldWindow", oWin[0], 72'h090807060504030201);
    acceptNow(0);
    check("t2.pixelReadyBack", 72'(oReady[0]), 72'd1);
    collectOnly(0);
    check("t2.x", 72'(oX[0]), 72'd1);
    check("t2.y", 72'(oY[0]), 72'd0);
    acceptNow(0);

    // Alternating pixelValid: junk bytes on idle beats must not land in the window
    for (int b = 0; b < 18; b++) begin
      dValid[0] = (b % 2 == 0);
      dPix[0]   = (b % 2 == 0) ? 8'(8'hA0 + b / 2) : 8'hEE;
      cycle();
    end
    dValid[0] = 0;
    check("t3.windowOut", oWin[0], 72'hA8A7A6A5A4A3A2A1A0);
    check("t3.x", 72'(oX[0]), 72'd2);
    acceptNow(0);

    // Row wrap on the full-size instance
    while (winAcc[0] < 237) randomBeat(0, 70, 60);
    collectOnly(0);
    check("t4.lastInRow", 72'({oX[0], oY[0]}), 72'({8'd237, 8'd0}));
    acceptNow(0);
    collectOnly(0);
    check("t4.rowWrap", 72'({oX[0], oY[0]}), 72'({8'd0, 8'd1}));
    acceptNow(0);

    // Reset after 4 bytes of a window; the next window must hold only fresh bytes
    for (int p = 0; p < 4; p++) begin
      dValid[0] = 1; dPix[0] = 8'(8'hC0 + p); cycle();
    end
    dValid[0] = 0;
    reset = 1; cycle(); reset = 0;
    checkResetState(0);
    dStart[0] = 1; cycle(); dStart[0] = 0;
    for (int p = 1; p <= 9; p++) begin
      dValid[0] = 1; dPix[0] = 8'(8'h30 + p); cycle();
    end
    dValid[0] = 0;
    check("t6.windowOut", oWin[0], 72'h393837363534333231);
    check("t6.xy", 72'({oX[0], oY[0]}), 72'd0);
    acceptNow(0);

    // Small-frame instance: frame with start held high relaunches, second frame ends idle
    dStart[1] = 1;
    while (frames[1] < 1) randomBeat(1, 70, 60);
    dValid[1] = 0; dReady[1] = 0;
    cycle();
    dStart[1] = 0;
    check("t5.relaunchBusy", 72'(oBusy[1]), 72'd1);
    while (frames[1] < 2) randomBeat(1, 70, 60);
    dValid[1] = 0; dReady[1] = 0;
    cycle();
    cycle();
    check("t5.idleBusy", 72'(oBusy[1]), 72'd0);
    check("t5.idleState", 72'(oState[1]), 72'd0);
    check("t5.windowsTotal", 72'(winAcc[1]), 72'(2 * (XL_B + 1) * (YL_B + 1)));

    summary();
  end
endmodule
